// File: rtl/nibble_serial_add_ctrl.sv
// Serial adder: one shared 4-bit add slice processes WIDTH-bit operands a nibble per clock,
// LSB first, with the carry rippled through a register; valid/ready on both sides.
module nibble_serial_add_ctrl #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int unsigned NIB   = WIDTH / 4;
  localparam int unsigned CNT_W = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ADD, S_DONE} state_t;

  state_t             r_state, w_state_nxt;
  logic [WIDTH-1:0]   r_a, w_a_nxt;
  logic [WIDTH-1:0]   r_b, w_b_nxt;
  logic [WIDTH-1:0]   r_sum, w_sum_nxt;
  logic               r_carry, w_carry_nxt;
  logic               r_cout, w_cout_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic               r_in_ready, w_in_ready_nxt;
  logic               r_out_valid, w_out_valid_nxt;
  logic               r_busy, w_busy_nxt;
  logic [4:0]         w_slice;

  // The single shared 4-bit slice: {c_out, s} = a + b + c_in
  assign w_slice = 5'(r_a[3:0]) + 5'(r_b[3:0]) + 5'(r_carry);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_carry     <= 1'b0;
      r_cout      <= 1'b0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_a         <= w_a_nxt;
      r_b         <= w_b_nxt;
      r_sum       <= w_sum_nxt;
      r_carry     <= w_carry_nxt;
      r_cout      <= w_cout_nxt;
      r_cnt       <= w_cnt_nxt;
      r_in_ready  <= w_in_ready_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  // Handshake flags are computed for the next state so they come straight from flops
  always_comb begin
    w_state_nxt     = r_state;
    w_a_nxt         = r_a;
    w_b_nxt         = r_b;
    w_sum_nxt       = r_sum;
    w_carry_nxt     = r_carry;
    w_cout_nxt      = r_cout;
    w_cnt_nxt       = r_cnt;
    w_in_ready_nxt  = r_in_ready;
    w_out_valid_nxt = r_out_valid;
    w_busy_nxt      = r_busy;
    case (r_state)
      S_IDLE: begin
        if (in_valid && r_in_ready) begin
          w_a_nxt        = a;
          w_b_nxt        = b;
          w_carry_nxt    = cin;
          w_cnt_nxt      = '0;
          w_in_ready_nxt = 1'b0;
          w_busy_nxt     = 1'b1;
          w_state_nxt    = S_ADD;
        end
      end
      S_ADD: begin
        w_sum_nxt   = {w_slice[3:0], r_sum[WIDTH-1:4]};
        w_a_nxt     = r_a >> 4;
        w_b_nxt     = r_b >> 4;
        w_carry_nxt = w_slice[4];
        w_cnt_nxt   = r_cnt + CNT_W'(1);
        if (r_cnt == CNT_W'(NIB - 1)) begin
          w_cout_nxt      = w_slice[4];
          w_cnt_nxt       = '0;
          w_out_valid_nxt = 1'b1;
          w_state_nxt     = S_DONE;
        end
      end
      S_DONE: begin
        // Handoff takes priority; a new op can only be accepted from IDLE
        if (out_ready) begin
          w_out_valid_nxt = 1'b0;
          w_in_ready_nxt  = 1'b1;
          w_busy_nxt      = 1'b0;
          w_state_nxt     = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign busy      = r_busy;

endmodule
